// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control sequencer: states,
// instruction classes, opcode/funct fields and the control-code values.
package mc_pkg;

  typedef enum logic [2:0] {
    S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CL_NONE, CL_BRANCH, CL_J, CL_JR, CL_JAL, CL_ALU, CL_LW, CL_SW
  } iclass_t;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [5:0] FN_JR     = 6'b001000;
  localparam logic [5:0] FN_ADDU   = 6'b100001;
  localparam logic [5:0] FN_SUBU   = 6'b100011;
  localparam logic [5:0] FN_AND    = 6'b100100;
  localparam logic [5:0] FN_OR     = 6'b100101;
  localparam logic [5:0] FN_SLT    = 6'b101010;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;

  localparam logic [2:0] BR_NONE   = 3'b000;
  localparam logic [2:0] BR_BLTZ   = 3'b010;
  localparam logic [2:0] BR_BGEZ   = 3'b011;
  localparam logic [2:0] BR_BEQ    = 3'b100;
  localparam logic [2:0] BR_BNE    = 3'b101;
  localparam logic [2:0] BR_BLEZ   = 3'b110;
  localparam logic [2:0] BR_BGTZ   = 3'b111;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_SLT   = 3'b100;
  localparam logic [2:0] ALU_LUI   = 3'b101;

  localparam logic [1:0] RD_RT     = 2'd0;
  localparam logic [1:0] RD_RD     = 2'd1;
  localparam logic [1:0] RD_RA     = 2'd2;

  localparam logic [1:0] WB_ALU    = 2'd0;
  localparam logic [1:0] WB_MEM    = 2'd1;
  localparam logic [1:0] WB_PC4    = 2'd2;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: opcode/funct/rt to instruction class
// and the control codes the sequencer latches in ID.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  output iclass_t    cls,
  output logic [2:0] branch_op,
  output logic [2:0] alu_op,
  output logic       alu_src_imm,
  output logic [1:0] reg_dst,
  output logic [1:0] wb_sel,
  output logic       illegal
);

  always_comb begin
    cls         = CL_NONE;
    branch_op   = BR_NONE;
    alu_op      = ALU_ADD;
    alu_src_imm = 1'b0;
    reg_dst     = RD_RT;
    wb_sel      = WB_ALU;
    illegal     = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        cls     = CL_ALU;
        reg_dst = RD_RD;
        case (funct)
          FN_JR:   begin cls = CL_JR; reg_dst = RD_RT; end
          FN_ADDU: alu_op = ALU_ADD;
          FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: begin cls = CL_NONE; reg_dst = RD_RT; illegal = 1'b1; end
        endcase
      end
      OP_REGIMM: begin
        if (rt == RT_BLTZ) begin
          cls = CL_BRANCH; branch_op = BR_BLTZ; alu_op = ALU_SUB;
        end else if (rt == RT_BGEZ) begin
          cls = CL_BRANCH; branch_op = BR_BGEZ; alu_op = ALU_SUB;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_BEQ:  begin cls = CL_BRANCH; branch_op = BR_BEQ;  alu_op = ALU_SUB; end
      OP_BNE:  begin cls = CL_BRANCH; branch_op = BR_BNE;  alu_op = ALU_SUB; end
      OP_BLEZ: begin cls = CL_BRANCH; branch_op = BR_BLEZ; alu_op = ALU_SUB; end
      OP_BGTZ: begin cls = CL_BRANCH; branch_op = BR_BGTZ; alu_op = ALU_SUB; end
      OP_J:    cls = CL_J;
      OP_JAL:  begin cls = CL_JAL; reg_dst = RD_RA; wb_sel = WB_PC4; end
      OP_ADDIU: begin cls = CL_ALU; alu_op = ALU_ADD; alu_src_imm = 1'b1; end
      OP_ORI:   begin cls = CL_ALU; alu_op = ALU_OR;  alu_src_imm = 1'b1; end
      OP_LUI:   begin cls = CL_ALU; alu_op = ALU_LUI; alu_src_imm = 1'b1; end
      OP_LW:    begin cls = CL_LW; alu_src_imm = 1'b1; wb_sel = WB_MEM; end
      OP_SW:    begin cls = CL_SW; alu_src_imm = 1'b1; end
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle IF/ID/EX/MEM/WB control sequencer with memory handshake,
// next-PC controls, write strobes and a retired-instruction counter.
module mc_ctrl_fsm
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  rt,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic        isj,
  output logic        isjr,
  output logic [2:0]  branch_op,
  output logic [2:0]  alu_op,
  output logic        alu_src_imm,
  output logic        reg_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wb_sel,
  output logic        halted,
  output logic [31:0] retired
);

  state_t     state_q, state_d;
  iclass_t    cls_q;
  logic [2:0] branch_q;

  iclass_t    dec_cls;
  logic [2:0] dec_br, dec_alu;
  logic       dec_imm, dec_ill;
  logic [1:0] dec_rd, dec_wb;

  mc_decode u_decode (
    .opcode      (opcode),
    .funct       (funct),
    .rt          (rt),
    .cls         (dec_cls),
    .branch_op   (dec_br),
    .alu_op      (dec_alu),
    .alu_src_imm (dec_imm),
    .reg_dst     (dec_rd),
    .wb_sel      (dec_wb),
    .illegal     (dec_ill)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cls_q       <= CL_NONE;
      branch_q    <= BR_NONE;
      alu_op      <= ALU_ADD;
      alu_src_imm <= 1'b0;
      reg_dst     <= RD_RT;
      wb_sel      <= WB_ALU;
    end else if (state_q == S_ID) begin
      cls_q       <= dec_cls;
      branch_q    <= dec_br;
      alu_op      <= dec_alu;
      alu_src_imm <= dec_imm;
      reg_dst     <= dec_rd;
      wb_sel      <= dec_wb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        retired <= '0;
    else if (pc_we) retired <= retired + 32'd1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:  if (mem_ready) state_d = S_ID;
      S_ID:  state_d = dec_ill ? S_HALT : S_EX;
      S_EX: begin
        case (cls_q)
          CL_BRANCH, CL_J, CL_JR: state_d = S_IF;
          CL_JAL, CL_ALU:         state_d = S_WB;
          CL_LW, CL_SW:           state_d = S_MEM;
          default:                state_d = S_HALT;
        endcase
      end
      S_MEM: if (mem_ready) state_d = (cls_q == CL_SW) ? S_IF : S_WB;
      S_WB:  state_d = S_IF;
      default: state_d = S_HALT;
    endcase
  end

  // State is already IF while rst is high, so every strobe is masked by rst
  // to keep all outputs at zero for the whole reset interval.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    isj       = 1'b0;
    isjr      = 1'b0;
    branch_op = BR_NONE;
    reg_we    = 1'b0;
    halted    = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IF: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
        end
        S_EX: begin
          case (cls_q)
            CL_BRANCH: begin branch_op = branch_q; pc_we = 1'b1; end
            CL_J:      begin isj = 1'b1;  pc_we = 1'b1; end
            CL_JR:     begin isjr = 1'b1; pc_we = 1'b1; end
            default:   ;
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_we  = (cls_q == CL_SW);
          pc_we   = (cls_q == CL_SW) && mem_ready;
        end
        S_WB: begin
          reg_we = 1'b1;
          pc_we  = 1'b1;
          isj    = (cls_q == CL_JAL);
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench: directed and random instructions with random memory
// wait states, checked cycle by cycle against a phase-list reference model.
module tb_mc_ctrl_fsm;
  import mc_pkg::*;

  localparam int K_BR = 0, K_J = 1, K_JR = 2, K_JAL = 3, K_ALU = 4,
                 K_LW = 5, K_SW = 6, K_ILL = 7;
  localparam int P_IF = 0, P_ID = 1, P_EX = 2, P_MEM = 3, P_WB = 4;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rt;
    bit         fn_dc;
    bit         rt_dc;
    int         kind;
    logic [2:0] br;
    logic [2:0] alu;
    logic       imm;
    logic [1:0] rd;
    logic [1:0] wb;
  } ins_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic [4:0]  rt = '0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, ir_we, pc_we, isj, isjr, alu_src_imm, reg_we, halted;
  logic [2:0]  branch_op, alu_op;
  logic [1:0]  reg_dst, wb_sel;
  logic [31:0] retired;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [31:0] retired_m = '0;
  ins_t        tbl[$];
  ins_t        ill_tbl[$];

  mc_ctrl_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .rt(rt),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we),
    .pc_we(pc_we), .isj(isj), .isjr(isjr), .branch_op(branch_op),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .reg_we(reg_we),
    .reg_dst(reg_dst), .wb_sel(wb_sel), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic ins_t mk(logic [5:0] op, logic [5:0] fn, logic [4:0] r,
                              bit fn_dc, bit rt_dc, int kind, logic [2:0] br,
                              logic [2:0] alu, logic imm, logic [1:0] rd, logic [1:0] wb);
    ins_t t;
    t.op = op; t.fn = fn; t.rt = r; t.fn_dc = fn_dc; t.rt_dc = rt_dc;
    t.kind = kind; t.br = br; t.alu = alu; t.imm = imm; t.rd = rd; t.wb = wb;
    return t;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {13'd0, mem_req, mem_we, ir_we, pc_we, isj, isjr, branch_op, alu_op,
            alu_src_imm, reg_we, reg_dst, wb_sel, halted, retired};
  endfunction

  // Entered and left just after a rising edge.
  task automatic do_reset();
    mem_ready = 1'b1;
    rst = 1'b1;
    #1 check("reset_async", all_outs(), 64'd0);
    @(posedge clk); #1;
    check("reset_held", all_outs(), 64'd0);
    rst = 1'b0;
    retired_m = '0;
  endtask

  // Reference model: the instruction is a list of phases, IF and MEM repeated
  // once per wait cycle; the final phase carries the PC write.
  task automatic run_instr(input ins_t t, input int ifw, input int mw, input int abort_at);
    int ph[$];
    bit last[$];
    for (int i = 0; i <= ifw; i++) begin ph.push_back(P_IF); last.push_back(i == ifw); end
    ph.push_back(P_ID); last.push_back(1'b0);
    if (t.kind != K_ILL) begin
      ph.push_back(P_EX); last.push_back(1'b0);
      if (t.kind == K_LW || t.kind == K_SW)
        for (int i = 0; i <= mw; i++) begin ph.push_back(P_MEM); last.push_back(i == mw); end
      if (t.kind == K_LW || t.kind == K_ALU || t.kind == K_JAL) begin
        ph.push_back(P_WB); last.push_back(1'b0);
      end
    end
    for (int c = 0; c < ph.size(); c++) begin
      logic [63:0] exp_v, obs_v;
      bit fin;
      if (c == abort_at) return;
      fin = (c == ph.size() - 1) && (t.kind != K_ILL);
      if (ph[c] == P_IF || ph[c] == P_MEM) mem_ready = last[c];
      else mem_ready = 1'($urandom);
      if (ph[c] == P_ID) begin
        opcode = t.op;
        funct  = t.fn_dc ? 6'($urandom) : t.fn;
        rt     = t.rt_dc ? 5'($urandom) : t.rt;
      end else begin
        opcode = 6'($urandom); funct = 6'($urandom); rt = 5'($urandom);
      end
      @(negedge clk);
      exp_v = {21'd0,
               1'(ph[c] == P_IF || ph[c] == P_MEM),
               1'(ph[c] == P_MEM && t.kind == K_SW),
               1'(ph[c] == P_IF && last[c]),
               1'(fin),
               1'(ph[c] == P_WB),
               1'((ph[c] == P_EX && t.kind == K_J) || (ph[c] == P_WB && t.kind == K_JAL)),
               1'(ph[c] == P_EX && t.kind == K_JR),
               (ph[c] == P_EX && t.kind == K_BR) ? t.br : 3'b000,
               1'b0,
               retired_m};
      obs_v = {21'd0, mem_req, mem_we, ir_we, pc_we, reg_we, isj, isjr, branch_op,
               halted, retired};
      check($sformatf("strobes op=%b ph=%0d c=%0d", t.op, ph[c], c), obs_v, exp_v);
      if (ph[c] >= P_EX)
        check($sformatf("decode op=%b c=%0d", t.op, c),
              {56'd0, alu_op, alu_src_imm, reg_dst, wb_sel},
              {56'd0, t.alu, t.imm, t.rd, t.wb});
      @(posedge clk); #1;
    end
    if (t.kind != K_ILL) retired_m = retired_m + 32'd1;
  endtask

  task automatic check_halt(input int n);
    for (int i = 0; i < n; i++) begin
      mem_ready = 1'($urandom);
      opcode = 6'($urandom); funct = 6'($urandom); rt = 5'($urandom);
      @(negedge clk);
      check("halt", {47'd0, mem_req, mem_we, ir_we, pc_we, reg_we, isj, isjr,
                     branch_op, halted, retired[5:0]},
            {47'd0, 7'd0, 3'd0, 1'b1, retired_m[5:0]});
      @(posedge clk); #1;
    end
  endtask

  initial begin
    tbl.push_back(mk(OP_BEQ,   '0, '0, 1, 1, K_BR,  BR_BEQ,  ALU_SUB, 0, RD_RT, WB_ALU)); // 0
    tbl.push_back(mk(OP_BNE,   '0, '0, 1, 1, K_BR,  BR_BNE,  ALU_SUB, 0, RD_RT, WB_ALU));
    tbl.push_back(mk(OP_BLEZ,  '0, '0, 1, 1, K_BR,  BR_BLEZ, ALU_SUB, 0, RD_RT, WB_ALU));
    tbl.push_back(mk(OP_BGTZ,  '0, '0, 1, 1, K_BR,  BR_BGTZ, ALU_SUB, 0, RD_RT, WB_ALU));
    tbl.push_back(mk(OP_REGIMM,'0, RT_BLTZ, 1, 0, K_BR, BR_BLTZ, ALU_SUB, 0, RD_RT, WB_ALU)); // 4
    tbl.push_back(mk(OP_REGIMM,'0, RT_BGEZ, 1, 0, K_BR, BR_BGEZ, ALU_SUB, 0, RD_RT, WB_ALU)); // 5
    tbl.push_back(mk(OP_J,     '0, '0, 1, 1, K_J,   3'b000,  ALU_ADD, 0, RD_RT, WB_ALU));
    tbl.push_back(mk(OP_RTYPE, FN_JR, '0, 0, 1, K_JR, 3'b000, ALU_ADD, 0, RD_RT, WB_ALU)); // 7
    tbl.push_back(mk(OP_JAL,   '0, '0, 1, 1, K_JAL, 3'b000,  ALU_ADD, 0, RD_RA, WB_PC4)); // 8
    tbl.push_back(mk(OP_RTYPE, FN_ADDU, '0, 0, 1, K_ALU, 3'b000, ALU_ADD, 0, RD_RD, WB_ALU)); // 9
    tbl.push_back(mk(OP_RTYPE, FN_SUBU, '0, 0, 1, K_ALU, 3'b000, ALU_SUB, 0, RD_RD, WB_ALU));
    tbl.push_back(mk(OP_RTYPE, FN_AND,  '0, 0, 1, K_ALU, 3'b000, ALU_AND, 0, RD_RD, WB_ALU));
    tbl.push_back(mk(OP_RTYPE, FN_OR,   '0, 0, 1, K_ALU, 3'b000, ALU_OR,  0, RD_RD, WB_ALU));
    tbl.push_back(mk(OP_RTYPE, FN_SLT,  '0, 0, 1, K_ALU, 3'b000, ALU_SLT, 0, RD_RD, WB_ALU));
    tbl.push_back(mk(OP_ADDIU, '0, '0, 1, 1, K_ALU, 3'b000, ALU_ADD, 1, RD_RT, WB_ALU));
    tbl.push_back(mk(OP_ORI,   '0, '0, 1, 1, K_ALU, 3'b000, ALU_OR,  1, RD_RT, WB_ALU));
    tbl.push_back(mk(OP_LUI,   '0, '0, 1, 1, K_ALU, 3'b000, ALU_LUI, 1, RD_RT, WB_ALU));
    tbl.push_back(mk(OP_LW,    '0, '0, 1, 1, K_LW,  3'b000, ALU_ADD, 1, RD_RT, WB_MEM)); // 17
    tbl.push_back(mk(OP_SW,    '0, '0, 1, 1, K_SW,  3'b000, ALU_ADD, 1, RD_RT, WB_ALU)); // 18

    ill_tbl.push_back(mk(6'b111111, '0, '0, 1, 1, K_ILL, 3'b000, ALU_ADD, 0, RD_RT, WB_ALU));
    ill_tbl.push_back(mk(OP_RTYPE, 6'b000000, '0, 0, 1, K_ILL, 3'b000, ALU_ADD, 0, RD_RT, WB_ALU));
    ill_tbl.push_back(mk(OP_REGIMM, '0, 5'b00010, 1, 0, K_ILL, 3'b000, ALU_ADD, 0, RD_RT, WB_ALU));

    @(posedge clk); #1;
    do_reset();

    run_instr(tbl[0], 0, 0, -1);   // beq, zero wait
    run_instr(tbl[17], 2, 3, -1);  // lw, 2 IF + 3 MEM waits
    run_instr(tbl[8], 0, 0, -1);   // jal
    run_instr(tbl[7], 0, 0, -1);   // jr
    run_instr(tbl[4], 0, 0, -1);   // bltz
    run_instr(tbl[5], 1, 0, -1);   // bgez
    run_instr(tbl[18], 0, 2, -1);  // sw

    for (int n = 0; n < 60; n++)
      run_instr(tbl[$urandom_range(0, tbl.size() - 1)],
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1);

    // sw abandoned by reset while waiting in MEM (IF, ID, EX, then 2nd MEM cycle)
    run_instr(tbl[18], 0, 4, 4);
    do_reset();
    run_instr(tbl[9], 0, 0, -1);

    // counter wrap
    force dut.retired = 32'hFFFF_FFFF;
    #1 release dut.retired;
    retired_m = 32'hFFFF_FFFF;
    run_instr(tbl[14], 0, 0, -1);
    run_instr(tbl[6], 0, 0, -1);

    for (int k = 0; k < ill_tbl.size(); k++) begin
      run_instr(ill_tbl[k], int'($urandom_range(0, 2)), 0, -1);
      check_halt(6);
      do_reset();
      run_instr(tbl[1], 0, 0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule
